edge_sched: RTL and testbench
=============================

EDGE_SCHED -- requirements
Module: edge_sched

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have ports: nreset  in  1  reset; synchronous, active-low.
REQ-003 SHALL have ports: winValid  in  1 / winReady  out  1  upstream 3x3 window handshake.
REQ-004 SHALL have ports: winPixels  in  3x3 array of 4-bit  window pixels; winX  in  10 / winY  in  9  centre coordinate.
REQ-005 SHALL have ports: detValid  out  1  detector start; detPixels  out  3x3 array of 4-bit; detX  out  10; detY  out  9.
REQ-006 SHALL have ports: detEdgeVal  in  2; detEdgeValid  in  1; detEdgeX  in  10; detEdgeY  in  9  detector result.
REQ-007 SHALL have ports: outValid  out  1 / outReady  in  1 result handshake; outEdge  out  2; outX  out  10; outY  out  9.
REQ-008 SHALL have ports: busy  out  1; frameDone  out  1  pulse; coordErr  out  1  sticky; timeoutErr  out  1  sticky.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT_RES, HOLD; only IDLE accepts a window.
REQ-010 SHALL drive winReady = (state==IDLE) combinationally; busy = (state!=IDLE).
REQ-011 IDLE: on winValid&&winReady SHALL register winPixels/winX/winY into detPixels/detX/detY and enter ISSUE next cycle.
REQ-012 ISSUE: SHALL assert detValid for exactly one cycle, then enter WAIT_RES; detValid SHALL be 0 in all other states.
REQ-013 detPixels/detX/detY SHALL stay constant from capture until the next window capture.
REQ-014 WAIT_RES: SHALL count cycles with a 3-bit counter cleared on entry.
REQ-015 On detEdgeValid in WAIT_RES, SHALL register detEdgeVal/detEdgeX/detEdgeY into outEdge/outX/outY and enter HOLD.
REQ-016 On that capture, SHALL set coordErr if detEdgeX!=detX or detEdgeY!=detY; result still forwarded.
REQ-017 detEdgeValid outside WAIT_RES SHALL be ignored.
REQ-018 HOLD: outValid=1 and outEdge/outX/outY stable; on outReady SHALL return to IDLE next cycle.
REQ-019 outValid SHALL be 1 only in HOLD; outReady while outValid=0 SHALL be ignored.
REQ-020 frameDone SHALL pulse one cycle on the HOLD handshake when outX==639 and outY==479.
REQ-021 Minimum window-to-window period SHALL be detector latency + 3 cycles (capture, issue, hold).

Reset
REQ-022 nreset=0 at a clock edge SHALL force IDLE and zero all registers: det*, out*, counter, coordErr, timeoutErr.
REQ-023 Reset mid-operation SHALL discard the in-flight window and any pending result; no outValid follows.
REQ-024 Sticky flags SHALL clear only by reset.

Configuration
REQ-025 Macro EDGE_SCHED_TIMEOUT_EN defined: if counter reaches 7 in WAIT_RES without detEdgeValid, SHALL set timeoutErr and return to IDLE, dropping the window.
REQ-026 If detEdgeValid arrives in the same cycle the counter reaches 7, the result SHALL win and no timeout is flagged.
REQ-027 Macro undefined: WAIT_RES SHALL wait indefinitely; timeoutErr tied 0.

Verification
REQ-028 Reset then window (X=5,Y=7, all pixels 0): winReady 0 during reset then 1; detValid one cycle pulse 2 cycles after handshake; result edge 0 presented at X=5,Y=7.
REQ-029 Window with left column 15, right 0, detector model 5-cycle latency: outEdge max code, outValid held across 3 cycles of outReady=0, then one transfer.
REQ-030 winValid held high continuously: winReady 0 from capture until HOLD handshake; exactly one detValid per accepted window, none dropped or duplicated.
REQ-031 Detector model returns X=6 for issued X=5: coordErr rises and stays 1 across subsequent windows until nreset.
REQ-032 With EDGE_SCHED_TIMEOUT_EN, detector silent: timeoutErr=1, back in IDLE, winReady=1, no outValid; result on the 7th-count cycle: no timeoutErr, outValid=1.
REQ-033 Result at X=639,Y=479: frameDone one-cycle pulse on handshake only; nreset asserted in WAIT_RES: no outValid afterwards.

Source files
------------

// File: rtl/edge_sched.sv
// edge_sched: schedules 3x3 pixel windows through an external edge detector.
//
// Accepts one window at a time from upstream, issues it to the detector with a
// single-cycle detValid pulse, waits for the detector result and presents it
// downstream until it is accepted. Only the IDLE state takes a new window.
//
// Ports
//   clk, nreset                        clock; synchronous active-low reset
//   winValid/winReady                  upstream window handshake
//   winPixels, winX, winY              window pixels [row][col] and centre coordinate
//   detValid, detPixels, detX, detY    detector start pulse and held window
//   detEdgeValid, detEdgeVal,
//   detEdgeX, detEdgeY                 detector result
//   outValid/outReady                  downstream result handshake
//   outEdge, outX, outY                forwarded result
//   busy                               a window is in flight
//   frameDone                          pulse on handing over the result at (639,479)
//   coordErr                           sticky: detector returned other coordinates
//   timeoutErr                         sticky: detector did not answer in time
//
// Build option
//   EDGE_SCHED_TIMEOUT_EN  give up on the detector after eight WAIT_RES cycles;
//                          when undefined, WAIT_RES waits forever and
//                          timeoutErr stays 0.
module edge_sched (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 winValid,
   output logic                 winReady,
   input  logic [2:0][2:0][3:0] winPixels,
   input  logic [9:0]           winX,
   input  logic [8:0]           winY,
   output logic                 detValid,
   output logic [2:0][2:0][3:0] detPixels,
   output logic [9:0]           detX,
   output logic [8:0]           detY,
   input  logic [1:0]           detEdgeVal,
   input  logic                 detEdgeValid,
   input  logic [9:0]           detEdgeX,
   input  logic [8:0]           detEdgeY,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [1:0]           outEdge,
   output logic [9:0]           outX,
   output logic [8:0]           outY,
   output logic                 busy,
   output logic                 frameDone,
   output logic                 coordErr,
   output logic                 timeoutErr
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, HOLD} stateT;

   stateT      state;
   logic [2:0] waitCnt;

   // Gated by nreset so upstream never sees a ready while reset is held.
   assign winReady  = nreset && state == IDLE;
   assign busy      = state != IDLE;
   assign detValid  = state == ISSUE;
   assign outValid  = state == HOLD;
   assign frameDone = outValid && outReady && outX == 10'd639 && outY == 9'd479;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state      <= IDLE;
         waitCnt    <= 3'd0;
         detPixels  <= '0;
         detX       <= 10'd0;
         detY       <= 9'd0;
         outEdge    <= 2'd0;
         outX       <= 10'd0;
         outY       <= 9'd0;
         coordErr   <= 1'b0;
         timeoutErr <= 1'b0;
      end else begin
         case (state)
            IDLE: if (winValid) begin
               detPixels <= winPixels;
               detX      <= winX;
               detY      <= winY;
               state     <= ISSUE;
            end
            ISSUE: begin
               waitCnt <= 3'd0;
               state   <= WAIT_RES;
            end
            WAIT_RES: begin
               waitCnt <= waitCnt + 3'd1;
               // A result arriving on the last counted cycle still wins over the timeout.
               if (detEdgeValid) begin
                  outEdge  <= detEdgeVal;
                  outX     <= detEdgeX;
                  outY     <= detEdgeY;
                  coordErr <= coordErr | (detEdgeX != detX) | (detEdgeY != detY);
                  state    <= HOLD;
               end
`ifdef EDGE_SCHED_TIMEOUT_EN
               else if (waitCnt == 3'd7) begin
                  timeoutErr <= 1'b1;
                  state      <= IDLE;
               end
`endif
            end
            HOLD: if (outReady) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_edge_sched.sv
// tb_edge_sched: randomized self-checking bench for edge_sched with a behavioural detector model.
module tb_edge_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 nreset, winValid, winReady, detValid, detEdgeValid;
   logic                 outValid, outReady, busy, frameDone, coordErr, timeoutErr;
   logic [2:0][2:0][3:0] winPixels, detPixels;
   logic [9:0]           winX, detX, detEdgeX, outX;
   logic [8:0]           winY, detY, detEdgeY, outY;
   logic [1:0]           detEdgeVal, outEdge;

   int checks = 0;
   int passes = 0;
   bit expCoordErr = 1'b0;
   bit expTimeoutErr = 1'b0;

   edge_sched dut (
      .clk(clk), .nreset(nreset),
      .winValid(winValid), .winReady(winReady),
      .winPixels(winPixels), .winX(winX), .winY(winY),
      .detValid(detValid), .detPixels(detPixels), .detX(detX), .detY(detY),
      .detEdgeVal(detEdgeVal), .detEdgeValid(detEdgeValid),
      .detEdgeX(detEdgeX), .detEdgeY(detEdgeY),
      .outValid(outValid), .outReady(outReady),
      .outEdge(outEdge), .outX(outX), .outY(outY),
      .busy(busy), .frameDone(frameDone),
      .coordErr(coordErr), .timeoutErr(timeoutErr)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Detector model: horizontal gradient of column sums quantised to 2 bits.
   function automatic logic [1:0] edgeOf(input logic [2:0][2:0][3:0] p);
      int l, r, d;
      l = 0;
      r = 0;
      for (int i = 0; i < 3; i++) begin
         l += int'(p[i][0]);
         r += int'(p[i][2]);
      end
      d = l > r ? l - r : r - l;
      return d >= 36 ? 2'd3 : d >= 24 ? 2'd2 : d >= 12 ? 2'd1 : 2'd0;
   endfunction

   function automatic logic [2:0][2:0][3:0] randPix();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[35:0];
   endfunction

   // One complete transaction: capture, issue, detector answers after lat cycles,
   // result held for stall cycles of outReady=0, then handed over.
   task automatic runWindow(input logic [9:0] x, input logic [8:0] y,
                            input logic [2:0][2:0][3:0] pix, input int lat,
                            input bit corrupt, input int stall, input bit keepValid);
      logic [1:0] e;
      logic [9:0] rx;
      e  = edgeOf(pix);
      rx = corrupt ? x + 10'd1 : x;
      winValid = 1'b1; winX = x; winY = y; winPixels = pix;
      #1;
      chk("winReady idle", winReady, 1);
      step();
      chk("detValid issue", detValid, 1);
      chk("busy issue", busy, 1);
      chk("detX capture", detX, x);
      chk("detY capture", detY, y);
      chk("detPixels capture", detPixels, pix);
      winValid = keepValid;
      winX = 10'($urandom()); winY = 9'($urandom()); winPixels = randPix();
      detEdgeValid = 1'($urandom_range(0, 1));
      detEdgeVal = 2'($urandom()); detEdgeX = 10'($urandom()); detEdgeY = 9'($urandom());
      outReady = 1'($urandom_range(0, 1));
      #1;
      chk("winReady busy", winReady, 0);
      for (int c = 1; c <= lat; c++) begin
         step();
         chk("detValid wait", detValid, 0);
         chk("outValid wait", outValid, 0);
         chk("winReady wait", winReady, 0);
         chk("detX hold", detX, x);
         chk("timeoutErr wait", timeoutErr, expTimeoutErr);
         detEdgeValid = (c == lat);
         detEdgeVal = e; detEdgeX = rx; detEdgeY = y;
         outReady = 1'($urandom_range(0, 1));
      end
      expCoordErr |= corrupt;
      step();
      detEdgeValid = 1'b1; detEdgeVal = ~e; detEdgeX = ~rx; detEdgeY = ~y;
      outReady = 1'b0;
      for (int s = 0; s <= stall; s++) begin
         if (s > 0) step();
         chk("outValid hold", outValid, 1);
         chk("outEdge", outEdge, e);
         chk("outX", outX, rx);
         chk("outY", outY, y);
         chk("detPixels hold", detPixels, pix);
         chk("coordErr", coordErr, expCoordErr);
         chk("timeoutErr", timeoutErr, expTimeoutErr);
         outReady = (s == stall);
         #1;
         chk("frameDone", frameDone, (s == stall) && rx == 10'd639 && y == 9'd479);
      end
      step();
      detEdgeValid = 1'b0; outReady = 1'b0;
      #1;
      chk("outValid after", outValid, 0);
      chk("busy after", busy, 0);
      chk("winReady after", winReady, 1);
      chk("detValid after", detValid, 0);
      chk("frameDone after", frameDone, 0);
   endtask

   task automatic randomWindows(input int n);
      for (int i = 0; i < n; i++)
         runWindow(10'($urandom()), 9'($urandom()), randPix(), $urandom_range(1, 8),
                   1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
   endtask

   initial begin
      logic [2:0][2:0][3:0] p;
      nreset = 1'b0; winValid = 1'b1; winX = 10'd3; winY = 9'd3; winPixels = '1;
      detEdgeValid = 1'b0; detEdgeVal = 2'd0; detEdgeX = 10'd0; detEdgeY = 9'd0;
      outReady = 1'b0;
      repeat (3) step();
      chk("reset winReady", winReady, 0);
      chk("reset busy", busy, 0);
      chk("reset detValid", detValid, 0);
      chk("reset outValid", outValid, 0);
      chk("reset detPixels", detPixels, 0);
      chk("reset detX", detX, 0);
      chk("reset detY", detY, 0);
      chk("reset outEdge", outEdge, 0);
      chk("reset outX", outX, 0);
      chk("reset outY", outY, 0);
      chk("reset coordErr", coordErr, 0);
      chk("reset timeoutErr", timeoutErr, 0);
      winValid = 1'b0; nreset = 1'b1;
      #1;
      chk("winReady released", winReady, 1);
      step();
      runWindow(10'd5, 9'd7, '0, 2, 1'b0, 0, 1'b0);
      p = '0;
      for (int i = 0; i < 3; i++) p[i][0] = 4'hF;
      runWindow(10'd20, 9'd30, p, 5, 1'b0, 3, 1'b0);
      randomWindows(16);
      runWindow(10'd639, 9'd479, randPix(), 3, 1'b0, 1, 1'b0);
      runWindow(10'd639, 9'd478, randPix(), 2, 1'b0, 0, 1'b0);
      runWindow(10'd5, 9'd7, randPix(), 4, 1'b1, 0, 1'b1);
      randomWindows(4);
      runWindow(10'd100, 9'd200, randPix(), 8, 1'b0, 2, 1'b0);
`ifdef EDGE_SCHED_TIMEOUT_EN
      winValid = 1'b1; winX = 10'd77; winY = 9'd66; winPixels = randPix();
      step();
      winValid = 1'b0;
      chk("timeout detValid", detValid, 1);
      for (int c = 1; c <= 8; c++) begin
         step();
         chk("timeout outValid", outValid, 0);
         chk("timeout busy", busy, 1);
         chk("timeout early", timeoutErr, 0);
      end
      step();
      expTimeoutErr = 1'b1;
      chk("timeoutErr set", timeoutErr, 1);
      chk("timeout winReady", winReady, 1);
      chk("timeout busy", busy, 0);
      chk("timeout outValid", outValid, 0);
      randomWindows(2);
`else
      runWindow(10'd300, 9'd100, randPix(), 12, 1'b0, 0, 1'b0);
`endif
      winValid = 1'b1; winX = 10'd100; winY = 9'd50; winPixels = randPix();
      step();
      winValid = 1'b0;
      step();
      step();
      chk("midop busy", busy, 1);
      nreset = 1'b0;
      step();
      nreset = 1'b1;
      expCoordErr = 1'b0;
      expTimeoutErr = 1'b0;
      #1;
      chk("midop winReady", winReady, 1);
      chk("midop busy", busy, 0);
      chk("midop detX", detX, 0);
      chk("midop outX", outX, 0);
      chk("midop coordErr", coordErr, 0);
      chk("midop timeoutErr", timeoutErr, 0);
      detEdgeValid = 1'b1; detEdgeVal = 2'd3; detEdgeX = 10'd100; detEdgeY = 9'd50;
      outReady = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("midop outValid", outValid, 0);
         chk("midop frameDone", frameDone, 0);
      end
      detEdgeValid = 1'b0; outReady = 1'b0;
      randomWindows(3);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
